hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It generalises the fixed two-operand, fixed-depth forwarding/stall logic.
- Tracks destination registers of in-flight instructions in a shift-register scoreboard across FWD_DEPTH post-decode stages.
- Each cycle it produces per-source forwarding selects, a load-use stall, and a flush-driven bubble.
- Sits beside the decode stage; the datapath forwarding muxes and the fetch/decode enables consume its outputs.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/hazard_scoreboard_src_match.sv | 36 +++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the hazard scoreboard: stage names, scoreboard entry, select constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY_ACCESS,
        WRITEBACK
    } stage_e;

    // Entry rd field is sized for the widest supported register address; narrower addresses are zero-extended.
    localparam int RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                is_load;
    } sb_entry_t;

    localparam int SEL_RF = 0;

    // A live entry is a real producer: x0 writes never create hazards.
    function automatic logic is_live(input sb_entry_t e);
        return e.valid && e.we && (e.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Per-operand compare: finds the youngest live producer of one source register and flags load-use.
module src_match
    import cpu_pkg::*;
#(
    parameter int REGISTER_SIZE = 5,
    parameter int FWD_DEPTH     = 3,
    parameter int LOAD_STAGE    = 2,
    parameter int SEL_W         = 2
) (
    input  sb_entry_t [FWD_DEPTH-1:0]     entries,
    input  logic      [REGISTER_SIZE-1:0] src_addr,
    input  logic                          src_used,
    output logic      [SEL_W-1:0]         fwd_sel,
    output logic                          load_stall
);

    logic [RD_MAX_W-1:0] src_ext;
    logic                found;

    assign src_ext = RD_MAX_W'(src_addr);

    // entries[0] is stage 1 (EXECUTE); scanning upward makes the youngest match win.
    always_comb begin
        fwd_sel    = SEL_W'(SEL_RF);
        load_stall = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (!found && src_used && is_live(entries[k]) && (entries[k].rd == src_ext)) begin
                found      = 1'b1;
                fwd_sel    = SEL_W'(k + 1);
                load_stall = ((k + 1) < LOAD_STAGE) && entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard of post-decode destinations.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_count counters.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int REGISTER_SIZE = 5,
    parameter int NUM_SRC       = 2,
    parameter int FWD_DEPTH     = 3,
    parameter int LOAD_STAGE    = 2,
    parameter int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic [REGISTER_SIZE-1:0]         issue_rd,
    input  logic                             issue_rd_we,
    input  logic                             issue_is_load,
    input  logic [NUM_SRC*REGISTER_SIZE-1:0] src_addr,
    input  logic [NUM_SRC-1:0]               src_used,
    input  logic                             flush,
    output logic                             stall,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
`ifdef HAZARD_STATS_EN
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      flush_count,
`endif
    output logic [FWD_DEPTH-1:0]             stage_valid
);

    sb_entry_t [FWD_DEPTH-1:0] stage_q, stage_d;
    logic      [NUM_SRC-1:0]   load_stall_vec;
    logic                      issue_accept;

    // Decode hands over an instruction when issue_valid is high and neither stall nor flush blocks it;
    // otherwise stage 1 takes a bubble. Stages behind it always advance.
    assign issue_accept = issue_valid && !stall && !flush;

    always_comb begin
        stage_d = '0;
        if (issue_accept) begin
            stage_d[0].valid   = 1'b1;
            stage_d[0].rd      = RD_MAX_W'(issue_rd);
            stage_d[0].we      = issue_rd_we;
            stage_d[0].is_load = issue_is_load;
        end
        for (int k = 1; k < FWD_DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_match #(
            .REGISTER_SIZE(REGISTER_SIZE),
            .FWD_DEPTH    (FWD_DEPTH),
            .LOAD_STAGE   (LOAD_STAGE),
            .SEL_W        (SEL_W)
        ) u_src_match (
            .entries   (stage_q),
            .src_addr  (src_addr[i*REGISTER_SIZE +: REGISTER_SIZE]),
            .src_used  (src_used[i]),
            .fwd_sel   (fwd_sel[i*SEL_W +: SEL_W]),
            .load_stall(load_stall_vec[i])
        );
    end

    assign stall = |load_stall_vec;

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            stage_valid[k] = stage_q[k].valid;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Both counters hold at all-ones rather than wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && issue_valid && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
